// File: rtl/ysyx_25060173_bus_pkg.sv
// Shared types and constants for the core's memory-bus blocks.
package ysyx_25060173_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_25060173_Reg.sv
// Team flop: synchronous active-high reset with write enable.
module ysyx_25060173_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_25060173_arb_pick.sv
// Winner selector for the two-master arbiter.
// YSYX_25060173_ARB_ROUND_ROBIN_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_25060173_arb_pick
    import ysyx_25060173_bus_pkg::*;
(
    input  logic [1:0] valid,
`ifdef YSYX_25060173_ARB_ROUND_ROBIN_EN
    input  logic       last,
`endif
    output logic       winner,
    output logic       any
);

    always_comb begin
        any = |valid;
`ifdef YSYX_25060173_ARB_ROUND_ROBIN_EN
        // On a tie the master that was not granted last time goes next.
        if (valid == 2'b11) begin
            winner = ~last;
        end else begin
            winner = valid[MST_LSU] ? MST_LSU : MST_IFU;
        end
`else
        winner = valid[MST_LSU] ? MST_LSU : MST_IFU;
`endif
    end

endmodule

// File: rtl/ysyx_25060173_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one outstanding transaction.
// Tie policy set by YSYX_25060173_ARB_ROUND_ROBIN_EN (round-robin) or fixed LSU priority.
module ysyx_25060173_mem_arbiter
    import ysyx_25060173_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wmask,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    output logic [DATA_W-1:0]   m0_resp_rdata,
    output logic                m0_resp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m1_resp_rdata,
    output logic                m1_resp_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_resp_rdata,
    input  logic                s_resp_err
);

    logic [1:0] state_q;
    arb_state_e state;
    arb_state_e state_next;
    logic       grant;
    logic       winner;
    logic       any_req;
    logic       grant_wen;

    assign state     = arb_state_e'(state_q);
    assign grant_wen = (state == IDLE) && any_req;

    ysyx_25060173_Reg #(.WIDTH(2), .RESET_VAL(IDLE)) u_state_reg (
        .clk(clk), .rst(~rst), .din(state_next), .dout(state_q), .wen(1'b1)
    );

    ysyx_25060173_Reg #(.WIDTH(1), .RESET_VAL(MST_IFU)) u_grant_reg (
        .clk(clk), .rst(~rst), .din(winner), .dout(grant), .wen(grant_wen)
    );

`ifdef YSYX_25060173_ARB_ROUND_ROBIN_EN
    logic last;

    // After reset the LSU counts as last granted, so the IFU wins the first tie.
    ysyx_25060173_Reg #(.WIDTH(1), .RESET_VAL(MST_LSU)) u_last_reg (
        .clk(clk), .rst(~rst), .din(winner), .dout(last), .wen(grant_wen)
    );

    ysyx_25060173_arb_pick u_pick (
        .valid({m1_req_valid, m0_req_valid}), .last(last), .winner(winner), .any(any_req)
    );
`else
    ysyx_25060173_arb_pick u_pick (
        .valid({m1_req_valid, m0_req_valid}), .winner(winner), .any(any_req)
    );
`endif

    logic sel_valid;
    logic sel_resp_ready;

    assign sel_valid      = (grant == MST_LSU) ? m1_req_valid  : m0_req_valid;
    assign sel_resp_ready = (grant == MST_LSU) ? m1_resp_ready : m0_resp_ready;

    // NOTE: every output gets a zero default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_resp_rdata = '0;
        m1_resp_rdata = '0;
        m0_resp_err   = 1'b0;
        m1_resp_err   = 1'b0;
        s_req_valid   = 1'b0;
        s_req_addr    = '0;
        s_req_wen     = 1'b0;
        s_req_wdata   = '0;
        s_req_wmask   = '0;
        s_resp_ready  = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) state_next = REQ;
            end
            REQ: begin
                s_req_valid = sel_valid;
                if (grant == MST_LSU) begin
                    s_req_addr   = m1_req_addr;
                    s_req_wen    = m1_req_wen;
                    s_req_wdata  = m1_req_wdata;
                    s_req_wmask  = m1_req_wmask;
                    m1_req_ready = s_req_ready;
                end else begin
                    s_req_addr   = m0_req_addr;
                    s_req_wen    = m0_req_wen;
                    s_req_wdata  = m0_req_wdata;
                    s_req_wmask  = m0_req_wmask;
                    m0_req_ready = s_req_ready;
                end
                // A master withdrawing its request is dropped rather than hanging the bus.
                if (sel_valid && s_req_ready) state_next = RESP;
                else if (!sel_valid)          state_next = IDLE;
            end
            RESP: begin
                s_resp_ready = sel_resp_ready;
                if (grant == MST_LSU) begin
                    m1_resp_valid = s_resp_valid;
                    m1_resp_rdata = s_resp_rdata;
                    m1_resp_err   = s_resp_err;
                end else begin
                    m0_resp_valid = s_resp_valid;
                    m0_resp_rdata = s_resp_rdata;
                    m0_resp_err   = s_resp_err;
                end
                if (s_resp_valid && sel_resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Directed self-checking bench for ysyx_25060173_mem_arbiter (either tie policy).
module tb_ysyx_25060173_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_valid;
    logic [31:0] m_addr  [2];
    logic [1:0]  m_wen;
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];
    logic [1:0]  m_resp_ready;

    logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid;
    logic        m0_resp_err, m1_resp_err;
    logic [31:0] m0_resp_rdata, m1_resp_rdata;

    logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready, s_resp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
    logic [3:0]  s_req_wmask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25060173_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m_valid[0]), .m0_req_ready(m0_req_ready), .m0_req_addr(m_addr[0]),
        .m0_req_wen(m_wen[0]), .m0_req_wdata(m_wdata[0]), .m0_req_wmask(m_wmask[0]),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m_resp_ready[0]),
        .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m_valid[1]), .m1_req_ready(m1_req_ready), .m1_req_addr(m_addr[1]),
        .m1_req_wen(m_wen[1]), .m1_req_wdata(m_wdata[1]), .m1_req_wmask(m_wmask[1]),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m_resp_ready[1]),
        .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic req_ready_of(input int m);
        return (m == 1) ? m1_req_ready : m0_req_ready;
    endfunction

    function automatic logic resp_valid_of(input int m);
        return (m == 1) ? m1_resp_valid : m0_resp_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 1) ? m1_resp_rdata : m0_resp_rdata;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 1) ? m1_resp_err : m0_resp_err;
    endfunction

    // Starts in IDLE just after a falling edge; master m must be the expected winner.
    task automatic run_txn(input int m, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] rdata, input logic err,
                           input int req_wait, input int resp_wait);
        int o = 1 - m;
        m_valid[m] = 1'b1;
        m_addr[m]  = addr;
        m_wen[m]   = wen;
        m_wdata[m] = wdata;
        m_wmask[m] = wmask;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        #1 check("idle_bubble", s_req_valid, 0);
        @(negedge clk);
        repeat (req_wait) begin
            #1 check("stall_req_valid", s_req_valid, 1);
            check("stall_req_ready", {req_ready_of(m), req_ready_of(o)}, 0);
            @(negedge clk);
        end
        s_req_ready = 1'b1;
        #1 check("req_valid", s_req_valid, 1);
        check("req_addr", s_req_addr, addr);
        check("req_wen", s_req_wen, wen);
        check("req_wdata", s_req_wdata, wdata);
        check("req_wmask", s_req_wmask, wmask);
        check("req_ready_pair", {req_ready_of(m), req_ready_of(o)}, 2'b10);
        @(negedge clk);
        m_valid[m]  = 1'b0;
        s_req_ready = 1'b0;
        repeat (resp_wait) begin
            #1 check("stall_resp_valid", resp_valid_of(m), 0);
            check("stall_resp_ready", s_resp_ready, 1);
            check("stall_other_rdy", req_ready_of(o), 0);
            @(negedge clk);
        end
        s_resp_valid = 1'b1;
        s_resp_rdata = rdata;
        s_resp_err   = err;
        #1 check("resp_valid", resp_valid_of(m), 1);
        check("resp_rdata", rdata_of(m), rdata);
        check("resp_err", err_of(m), err);
        check("other_resp_quiet", {resp_valid_of(o), err_of(o), rdata_of(o)}, 0);
        check("s_req_quiet_resp", s_req_valid, 0);
        @(negedge clk);
        s_resp_valid = 1'b0;
        s_resp_rdata = '0;
        s_resp_err   = 1'b0;
        #1 check("back_idle", {s_req_valid, s_resp_ready, req_ready_of(0), req_ready_of(1)}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
`ifdef YSYX_25060173_ARB_ROUND_ROBIN_EN
        first = 0;
`else
        first = 1;
`endif
        rst          = 1'b0;
        m_valid      = 2'b11;
        m_wen        = 2'b00;
        m_resp_ready = 2'b11;
        m_addr[0]  = 32'h8000_0000; m_addr[1]  = 32'h1000_0000;
        m_wdata[0] = '0;            m_wdata[1] = '0;
        m_wmask[0] = '0;            m_wmask[1] = '0;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_resp_rdata = '0;
        s_resp_err   = 1'b0;

        // Reset held for three edges with both masters requesting.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            #1 check("rst_quiet", {m0_req_ready, m1_req_ready, s_req_valid,
                                   m0_resp_valid, m1_resp_valid, s_resp_ready}, 0);
            check("rst_payload", s_req_addr, 0);
        end
        rst = 1'b1;

        // Simultaneous requests: first grant on the first edge after release.
        run_txn(first,     m_addr[first],     1'b0, 32'h0, 4'h0, 32'h1111_0000, 1'b0, 0, 0);
        run_txn(1 - first, m_addr[1 - first], 1'b0, 32'h0, 4'h0, 32'h2222_0000, 1'b0, 0, 0);
        m_valid = 2'b11;
        run_txn(first,     32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h3333_0000, 1'b0, 0, 0);
        run_txn(1 - first, 32'h1000_0010, 1'b0, 32'h0, 4'h0, 32'h4444_0000, 1'b0, 0, 0);

        // Single IFU read, zero-wait slave.
        run_txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 0, 0);

        // Slave stalls on the LSU while the IFU waits; both policies pick the LSU here.
        m_valid[0] = 1'b1;
        m_addr[0]  = 32'h8000_0020;
        run_txn(1, 32'h1000_0040, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 5, 7);
        run_txn(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'hCAFE_0002, 1'b0, 0, 0);

        // LSU partial write with slave error.
        run_txn(1, 32'h2000_0004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b1, 0, 0);

        // Granted master withdraws its request before the handshake.
        m_valid[0] = 1'b1;
        @(negedge clk);
        #1 check("withdraw_req", s_req_valid, 1);
        m_valid[0] = 1'b0;
        @(negedge clk);
        #1 check("withdraw_idle", {s_req_valid, m0_req_ready}, 0);

        // Reset while in RESP abandons the transaction.
        m_valid[0]      = 1'b1;
        m_resp_ready[0] = 1'b0;
        @(negedge clk);
        s_req_ready = 1'b1;
        @(negedge clk);
        m_valid[0]   = 1'b0;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h0000_0055;
        #1 check("mid_resp_valid", {m0_resp_valid, s_resp_ready}, 2'b10);
        rst = 1'b0;
        @(negedge clk);
        #1 check("mid_rst_quiet", {m0_resp_valid, m1_resp_valid, s_resp_ready,
                                   s_req_valid, m0_req_ready, m1_req_ready}, 0);
        check("mid_rst_rdata", m0_resp_rdata, 0);
        rst             = 1'b1;
        s_resp_valid    = 1'b0;
        s_resp_rdata    = '0;
        m_resp_ready[0] = 1'b1;
        @(negedge clk);
        #1 check("post_rst_idle", {s_req_valid, m0_resp_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
